// File: rtl/level_hv_gen.sv
// level_hv_gen: generates NUM_LVL segment-sparse, progressively decorrelated level
// hypervectors and strobes each one (with its level index) into the level-HV bank.
// Optional feature macro: LVL_GEN_ABORT_EN adds an 'abort' input that cancels a run.
module level_hv_gen #(
    parameter int unsigned HV_DIM       = 1024,
    parameter int unsigned SEG_LEN      = 32,
    parameter int unsigned NUM_LVL      = 9,
    parameter int unsigned FLIP_PER_LVL = 4,
    parameter logic [15:0] DEF_SEED     = 16'hACE1
) (
    input  logic              clk,
    input  logic              nrst,
`ifdef LVL_GEN_ABORT_EN
    input  logic              abort,
`endif
    input  logic              start,
    input  logic              seed_load,
    input  logic [15:0]       seed,
    output logic              busy,
    output logic              done,
    output logic              mapping_hv_segment,
    output logic [3:0]        sel,
    output logic [HV_DIM-1:0] level_hv
);

    localparam int unsigned NUM_SEG   = HV_DIM / SEG_LEN;
    localparam int unsigned IDX_W     = $clog2(SEG_LEN);
    localparam int unsigned SEGC_W    = $clog2(NUM_SEG);
    localparam int unsigned LVL_W     = 4;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEED = 3'd1;
    localparam logic [2:0] S_EMIT = 3'd2;
    localparam logic [2:0] S_FLIP = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [HV_DIM-1:0]   hv_work_q, hv_work_d;
    logic [SEGC_W-1:0]   seg_cnt_q, seg_cnt_d;
    logic [LVL_W-1:0]    lvl_q, lvl_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                strobe_q, strobe_d;
    logic [LVL_W-1:0]    sel_q, sel_d;

    logic [15:0]         lfsr_adv;
    logic [IDX_W-1:0]    draw;
    logic [IDX_W-1:0]    draw_eff;
    logic [SEGC_W-1:0]   seg_idx;
    logic [SEG_LEN-1:0]  cur_seg;
    logic [IDX_W-1:0]    cur_idx;
    logic [SEG_LEN-1:0]  onehot;

    // Datapath helpers: LFSR advance, target segment, its current hot index, adjusted draw
    always_comb begin
        lfsr_adv = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0);
        draw     = lfsr_q[IDX_W-1:0];
        if (state_q == S_FLIP) begin
            seg_idx = SEGC_W'((32'(lvl_q) - 32'd1) * FLIP_PER_LVL + 32'(seg_cnt_q));
        end else begin
            seg_idx = seg_cnt_q;
        end
        cur_seg = hv_work_q[32'(seg_idx) * SEG_LEN +: SEG_LEN];
        cur_idx = '0;
        for (int unsigned b = 0; b < SEG_LEN; b++) begin
            if (cur_seg[b]) begin
                cur_idx = IDX_W'(b);
            end
        end
        // A re-drawn segment must actually move its hot bit
        if ((state_q == S_FLIP) && (draw == cur_idx)) begin
            draw_eff = draw + IDX_W'(1);
        end else begin
            draw_eff = draw;
        end
        onehot = {{(SEG_LEN-1){1'b0}}, 1'b1} << draw_eff;
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        hv_work_d = hv_work_q;
        seg_cnt_d = seg_cnt_q;
        lvl_d     = lvl_q;
        sel_d     = sel_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        strobe_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_SEED;
                    seg_cnt_d = '0;
                    lvl_d     = '0;
                    hv_work_d = '0;
                end else if (seed_load) begin
                    lfsr_d = (seed == 16'h0) ? DEF_SEED : seed;
                end
            end
            S_SEED: begin
                hv_work_d[32'(seg_idx) * SEG_LEN +: SEG_LEN] = onehot;
                lfsr_d = lfsr_adv;
                if (seg_cnt_q == SEGC_W'(NUM_SEG - 1)) begin
                    seg_cnt_d = '0;
                    state_d   = S_EMIT;
                end else begin
                    seg_cnt_d = seg_cnt_q + SEGC_W'(1);
                end
            end
            S_EMIT: begin
                if (lvl_q == LVL_W'(NUM_LVL - 1)) begin
                    state_d = S_DONE;
                end else begin
                    lvl_d     = lvl_q + LVL_W'(1);
                    seg_cnt_d = '0;
                    state_d   = S_FLIP;
                end
            end
            S_FLIP: begin
                hv_work_d[32'(seg_idx) * SEG_LEN +: SEG_LEN] = onehot;
                lfsr_d = lfsr_adv;
                if (seg_cnt_q == SEGC_W'(FLIP_PER_LVL - 1)) begin
                    seg_cnt_d = '0;
                    state_d   = S_EMIT;
                end else begin
                    seg_cnt_d = seg_cnt_q + SEGC_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef LVL_GEN_ABORT_EN
        // Abort freezes the working state and drops straight back to IDLE
        if (abort && ((state_q == S_SEED) || (state_q == S_FLIP) || (state_q == S_EMIT))) begin
            state_d   = S_IDLE;
            lfsr_d    = lfsr_q;
            hv_work_d = hv_work_q;
            seg_cnt_d = seg_cnt_q;
            lvl_d     = lvl_q;
        end
`endif

        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        strobe_d = (state_d == S_EMIT);
        if (strobe_d) begin
            sel_d = lvl_d;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_IDLE;
            lfsr_q    <= DEF_SEED;
            hv_work_q <= '0;
            seg_cnt_q <= '0;
            lvl_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            strobe_q  <= 1'b0;
            sel_q     <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            hv_work_q <= hv_work_d;
            seg_cnt_q <= seg_cnt_d;
            lvl_q     <= lvl_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            strobe_q  <= strobe_d;
            sel_q     <= sel_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sel      = sel_q;
    assign level_hv = hv_work_q;
`ifdef LVL_GEN_ABORT_EN
    // An abort during EMIT suppresses that cycle's strobe
    assign mapping_hv_segment = strobe_q & ~abort;
`else
    assign mapping_hv_segment = strobe_q;
`endif

endmodule

// File: tb/tb_level_hv_gen.sv
// tb_level_hv_gen: directed bench for level_hv_gen with a scoreboard of expected strobes.
// Optional feature macro: LVL_GEN_ABORT_EN (enables the abort scenario).
module tb_level_hv_gen;

    localparam int unsigned HV_DIM  = 1024;
    localparam int unsigned SEG_LEN = 32;
    localparam int unsigned NUM_SEG = 32;
    localparam int unsigned NUM_LVL = 9;
    localparam int unsigned FLIP    = 4;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              start = 1'b0;
    logic              seed_load = 1'b0;
    logic [15:0]       seed = 16'h0;
`ifdef LVL_GEN_ABORT_EN
    logic              abort = 1'b0;
`endif
    logic              busy;
    logic              done;
    logic              mapping_hv_segment;
    logic [3:0]        sel;
    logic [HV_DIM-1:0] level_hv;

    always #5 clk = ~clk;

    level_hv_gen dut (
        .clk                (clk),
        .nrst               (nrst),
`ifdef LVL_GEN_ABORT_EN
        .abort              (abort),
`endif
        .start              (start),
        .seed_load          (seed_load),
        .seed               (seed),
        .busy               (busy),
        .done               (done),
        .mapping_hv_segment (mapping_hv_segment),
        .sel                (sel),
        .level_hv           (level_hv)
    );

    typedef struct {
        logic [3:0]        sel;
        logic [HV_DIM-1:0] hv;
        int                cyc;
    } exp_t;

    exp_t              sb[$];
    logic [HV_DIM-1:0] model_lvl [NUM_LVL];
    int                total = 0;
    int                bad = 0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0);
    endfunction

    // Software reference of the level sequence for a given seed
    task automatic build_model(input logic [15:0] sd);
        logic [15:0]       lf;
        logic [HV_DIM-1:0] hv;
        int                s;
        int                d;
        int                cur;
        lf = (sd == 16'h0) ? 16'hACE1 : sd;
        hv = '0;
        for (int i = 0; i < NUM_SEG; i++) begin
            d = int'(lf[4:0]);
            hv[i * SEG_LEN + d] = 1'b1;
            lf = lfsr_step(lf);
        end
        model_lvl[0] = hv;
        for (int k = 1; k < NUM_LVL; k++) begin
            for (int j = 0; j < FLIP; j++) begin
                s   = (k - 1) * FLIP + j;
                cur = -1;
                for (int b = 0; b < SEG_LEN; b++) begin
                    if (hv[s * SEG_LEN + b]) cur = b;
                end
                d = int'(lf[4:0]);
                if (d == cur) d = (d + 1) % SEG_LEN;
                hv[s * SEG_LEN +: SEG_LEN] = '0;
                hv[s * SEG_LEN + d] = 1'b1;
                lf = lfsr_step(lf);
            end
            model_lvl[k] = hv;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_hv(input string tag, input logic [HV_DIM-1:0] obs, input logic [HV_DIM-1:0] exp);
        int sb_idx;
        sb_idx = 0;
        for (int s = NUM_SEG - 1; s >= 0; s--) begin
            if (obs[s * SEG_LEN +: SEG_LEN] !== exp[s * SEG_LEN +: SEG_LEN]) sb_idx = s;
        end
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s seg=%0d observed=%h expected=%h", tag, sb_idx,
                   obs[sb_idx * SEG_LEN +: SEG_LEN], exp[sb_idx * SEG_LEN +: SEG_LEN]);
        end
    endtask

    function automatic bit segs_onehot(input logic [HV_DIM-1:0] hv);
        bit ok;
        ok = 1'b1;
        for (int s = 0; s < NUM_SEG; s++) begin
            if ($countones(hv[s * SEG_LEN +: SEG_LEN]) != 1) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic load_seed(input logic [15:0] v);
        @(negedge clk);
        seed      = v;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_strobe"}, 64'(mapping_hv_segment), 64'd0);
        chk({tag, "_sel"}, 64'(sel), 64'd0);
        chk_hv({tag, "_hv"}, level_hv, '0);
    endtask

    // One run: start at cycle 0, scoreboard every strobe, optional disturbances at given cycles
    task automatic run(input logic [15:0] model_seed, input int restart_cyc, input int load_cyc,
                       input int rst_cyc, input int abort_cyc, output logic [HV_DIM-1:0] lv0);
        exp_t e;
        bit   saw_done;
        int   cyc;
        build_model(model_seed);
        sb.delete();
        for (int k = 0; k < NUM_LVL; k++) begin
            e.sel = 4'(k);
            e.hv  = model_lvl[k];
            e.cyc = 33 + 5 * k;
            sb.push_back(e);
        end
        saw_done = 1'b0;
        lv0      = '0;
        @(negedge clk);
        start = 1'b1;
        cyc   = 0;
        while (cyc < 90) begin
            @(negedge clk);
            cyc++;
            if (cyc == rst_cyc) begin
                nrst = 1'b0;
                #1;
                check_reset_outputs("midrun_rst");
                sb.delete();
                @(negedge clk);
                nrst  = 1'b1;
                start = 1'b0;
                return;
            end
            if (mapping_hv_segment) begin
                chk("strobe_expected", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("strobe_sel", 64'(sel), 64'(e.sel));
                    chk("strobe_cycle", 64'(cyc), 64'(e.cyc));
                    chk_hv("strobe_hv", level_hv, e.hv);
                    chk("popcount", 64'($countones(level_hv)), 64'(NUM_SEG));
                    chk("seg_onehot", 64'(segs_onehot(level_hv)), 64'd1);
                    if (e.sel == 4'd0) begin
                        lv0 = level_hv;
                    end else begin
                        chk("hamming_lvl0", 64'($countones(level_hv ^ lv0)), 64'(2 * FLIP * int'(e.sel)));
                        chk("untouched_segs", 64'(((level_hv ^ lv0) >> (FLIP * int'(e.sel) * SEG_LEN)) == '0), 64'd1);
                    end
                end
            end
            if (done) begin
                chk("done_cycle", 64'(cyc), 64'd74);
                saw_done = 1'b1;
            end
            if (cyc == 1) chk("busy_after_start", 64'(busy), 64'd1);
            if (abort_cyc < 0) begin
                if (cyc == 74) chk("busy_at_done", 64'(busy), 64'd1);
                if (cyc == 75) chk("busy_after_done", 64'(busy), 64'd0);
            end else if (cyc == abort_cyc + 1) begin
                chk("busy_after_abort", 64'(busy), 64'd0);
            end
            start     = (cyc == restart_cyc);
            seed_load = (cyc == load_cyc);
            if (cyc == load_cyc) seed = 16'h1234;
`ifdef LVL_GEN_ABORT_EN
            abort = (cyc == abort_cyc);
`endif
            if (cyc == abort_cyc) sb.delete();
        end
        start     = 1'b0;
        seed_load = 1'b0;
        chk("pending_strobes", 64'(sb.size()), 64'd0);
        chk("done_seen", 64'(saw_done), 64'(abort_cyc < 0));
    endtask

    logic [HV_DIM-1:0] lv0_ace;
    logic [HV_DIM-1:0] lv0_tmp;

    initial begin
        // Reset state
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        nrst = 1'b1;
        @(negedge clk);

        // Basic run from the reset seed
        run(16'hACE1, -1, -1, -1, -1, lv0_ace);

        // Seed 0 maps to the default seed; explicit default gives the same sequence
        load_seed(16'h0000);
        run(16'h0000, -1, -1, -1, -1, lv0_tmp);
        chk_hv("seed0_lvl0_same", lv0_tmp, lv0_ace);
        load_seed(16'hACE1);
        run(16'hACE1, -1, -1, -1, -1, lv0_tmp);
        chk_hv("seedace1_lvl0_same", lv0_tmp, lv0_ace);
        load_seed(16'h1234);
        run(16'h1234, -1, -1, -1, -1, lv0_tmp);
        chk("seed1234_lvl0_differs", 64'(lv0_tmp !== lv0_ace), 64'd1);

        // start and seed_load while busy are ignored
        load_seed(16'hACE1);
        run(16'hACE1, 10, 40, -1, -1, lv0_tmp);

        // Async reset mid-run, then a full run from the reset seed
        load_seed(16'h1234);
        run(16'h1234, -1, -1, 50, -1, lv0_tmp);
        run(16'hACE1, -1, -1, -1, -1, lv0_tmp);
        chk_hv("post_reset_lvl0", lv0_tmp, lv0_ace);

`ifdef LVL_GEN_ABORT_EN
        // Abort during FLIP after the first strobe
        load_seed(16'hACE1);
        run(16'hACE1, -1, -1, -1, 36, lv0_tmp);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
